// File: rtl/regfile_writeback_queue_pkg.sv
// Shared definitions for the register-file write-back queue.
//   REG_ADDR_W / DATA_W : register address and data widths
//   REG_ZERO            : hard-wired zero register, never written
//   wb_entry_t          : one queued write {dir, dato}
//   clog2()             : ceiling log2, usable in constant expressions
package regfile_writeback_queue_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dir;
        logic [DATA_W-1:0]     dato;
    } wb_entry_t;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO holding long-latency write-back results.
//   clk, rst_n : clock, synchronous active-low reset (drops all entries)
//   push, wdata: write one entry (caller guarantees not full)
//   pop, head  : head entry and its removal (caller guarantees not empty)
//   full, empty, count : occupancy status
//   valid, dirs: per-slot occupancy mask and flat destination addresses,
//                used by the hazard comparators in the top
module wb_fifo
    import regfile_writeback_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  wb_entry_t                      wdata,
    input  logic                           pop,
    output wb_entry_t                      head,
    output logic                           full,
    output logic                           empty,
    output logic [clog2(DEPTH+1)-1:0]      count,
    output logic [DEPTH-1:0]               valid,
    output logic [DEPTH*REG_ADDR_W-1:0]    dirs
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt;
    logic [PTR_W-1:0] offs;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // NOTE: the storage array has no reset; an entry is only observable once
    // the pointers/count say it is valid, so resetting it would buy nothing.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign head  = mem[rd_ptr];
    assign count = cnt;
    assign full  = (cnt == CNT_W'(DEPTH));
    assign empty = (cnt == '0);

    // A slot is occupied when its distance from the read pointer is below count.
    always_comb begin
        offs  = '0;
        valid = '0;
        dirs  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offs     = PTR_W'(i) - rd_ptr;
            valid[i] = (CNT_W'(offs) < cnt);
            dirs[i*REG_ADDR_W +: REG_ADDR_W] = mem[i].dir;
        end
    end

endmodule

// File: rtl/regfile_writeback_queue.sv
// Write-side front end for the register file's single write port.
//   alu_we/alu_dir/alu_dato          : single-cycle ALU result, never back-pressured
//   lat_valid/lat_ready/lat_dir/lat_dato : long-latency result handshake into a FIFO
//   rd_dir1/rd_dir2 -> pend1/pend2   : decode hazard flags (queued write pending)
//   RWEN/DirWrite/DatoNuevo          : registered register-file write port
//   pide_stall                       : asks pipeline to hold off ALU writes next cycle
//   err_colision                     : sticky, ALU write arrived during pide_stall
//   ocupacion                        : FIFO entry count
module regfile_writeback_queue
    import regfile_writeback_queue_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alu_we,
    input  logic [REG_ADDR_W-1:0]      alu_dir,
    input  logic [DATA_W-1:0]          alu_dato,
    input  logic                       lat_valid,
    output logic                       lat_ready,
    input  logic [REG_ADDR_W-1:0]      lat_dir,
    input  logic [DATA_W-1:0]          lat_dato,
    input  logic [REG_ADDR_W-1:0]      rd_dir1,
    input  logic [REG_ADDR_W-1:0]      rd_dir2,
    output logic                       pend1,
    output logic                       pend2,
    output logic                       RWEN,
    output logic [REG_ADDR_W-1:0]      DirWrite,
    output logic [DATA_W-1:0]          DatoNuevo,
    output logic                       pide_stall,
    output logic                       err_colision,
    output logic [clog2(DEPTH+1)-1:0]  ocupacion
);

    localparam int ST_W = clog2(STARVE_MAX + 1);

    logic                        push;
    logic                        pop;
    logic                        full;
    logic                        empty;
    logic                        alu_req;
    logic                        alu_win;
    logic                        starve_hit;
    logic [ST_W-1:0]             starve_cnt;
    wb_entry_t                   wdata;
    wb_entry_t                   head;
    logic [DEPTH-1:0]            valid;
    logic [DEPTH*REG_ADDR_W-1:0] dirs;

    assign lat_ready = !full;
    assign wdata     = '{dir: lat_dir, dato: lat_dato};
    // A zero-destination result completes its handshake but is never stored.
    assign push      = lat_valid && lat_ready && (lat_dir != REG_ZERO);

    assign alu_req   = alu_we && (alu_dir != REG_ZERO);
    assign alu_win   = alu_req && !pide_stall;
    // During pide_stall alu_win is low, so the head pops unconditionally.
    assign pop       = !empty && !alu_win;
    assign starve_hit = alu_win && !empty && (starve_cnt == ST_W'(STARVE_MAX - 1));

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (ocupacion),
        .valid (valid),
        .dirs  (dirs)
    );

    // NOTE: every state register below uses non-blocking assignment so all
    // of them update together from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            RWEN         <= 1'b0;
            DirWrite     <= '0;
            DatoNuevo    <= '0;
            pide_stall   <= 1'b0;
            err_colision <= 1'b0;
            starve_cnt   <= '0;
        end else begin
            RWEN <= alu_win || pop;
            // Address/data hold when no write issues.
            if (alu_win) begin
                DirWrite  <= alu_dir;
                DatoNuevo <= alu_dato;
            end else if (pop) begin
                DirWrite  <= head.dir;
                DatoNuevo <= head.dato;
            end
            if (pide_stall && alu_req) err_colision <= 1'b1;
            pide_stall <= starve_hit;
            if (pop || empty)  starve_cnt <= '0;
            else if (alu_win)  starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // The output stage is excluded: that write lands in the register file now.
    // NOTE: both flags get a default first so no latch is inferred.
    always_comb begin
        pend1 = 1'b0;
        pend2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (dirs[i*REG_ADDR_W +: REG_ADDR_W] == rd_dir1)) pend1 = 1'b1;
            if (valid[i] && (dirs[i*REG_ADDR_W +: REG_ADDR_W] == rd_dir2)) pend2 = 1'b1;
        end
        if (rd_dir1 == REG_ZERO) pend1 = 1'b0;
        if (rd_dir2 == REG_ZERO) pend2 = 1'b0;
    end

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Directed self-checking bench for regfile_writeback_queue.
module tb_regfile_writeback_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_we;
    logic [4:0]  alu_dir;
    logic [31:0] alu_dato;
    logic        lat_valid;
    logic        lat_ready;
    logic [4:0]  lat_dir;
    logic [31:0] lat_dato;
    logic [4:0]  rd_dir1;
    logic [4:0]  rd_dir2;
    logic        pend1;
    logic        pend2;
    logic        RWEN;
    logic [4:0]  DirWrite;
    logic [31:0] DatoNuevo;
    logic        pide_stall;
    logic        err_colision;
    logic [2:0]  ocupacion;

    int checks = 0;
    int errors = 0;

    // Register-file model written by the port, as the real register file is.
    logic [31:0] rf [32];
    logic        wrote9 = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (RWEN) begin
            rf[DirWrite] <= DatoNuevo;
            if (DirWrite == 5'd9) wrote9 <= 1'b1;
        end
    end

    regfile_writeback_queue dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_we       (alu_we),
        .alu_dir      (alu_dir),
        .alu_dato     (alu_dato),
        .lat_valid    (lat_valid),
        .lat_ready    (lat_ready),
        .lat_dir      (lat_dir),
        .lat_dato     (lat_dato),
        .rd_dir1      (rd_dir1),
        .rd_dir2      (rd_dir2),
        .pend1        (pend1),
        .pend2        (pend2),
        .RWEN         (RWEN),
        .DirWrite     (DirWrite),
        .DatoNuevo    (DatoNuevo),
        .pide_stall   (pide_stall),
        .err_colision (err_colision),
        .ocupacion    (ocupacion)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        alu_we = 1'b1; alu_dir = 5'd5; alu_dato = 32'hDEAD;
        lat_valid = 1'b1; lat_dir = 5'd2; lat_dato = 32'hBEEF;
        rd_dir1 = 5'd0; rd_dir2 = 5'd0;
        tick();
        tick();
        checks++; if (RWEN !== 1'b0) begin errors++; $display("FAIL reset_rwen: got %0b want 0", RWEN); end
        checks++; if (DirWrite !== 5'd0) begin errors++; $display("FAIL reset_dir: got %0d want 0", DirWrite); end
        checks++; if (DatoNuevo !== 32'h0) begin errors++; $display("FAIL reset_dato: got %0h want 0", DatoNuevo); end
        checks++; if (pide_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", pide_stall); end
        checks++; if (err_colision !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", err_colision); end
        checks++; if (ocupacion !== 3'd0) begin errors++; $display("FAIL reset_ocup: got %0d want 0", ocupacion); end
        checks++; if (lat_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", lat_ready); end
        // First cycle after release: ALU write r5.
        rst_n = 1'b1;
        lat_valid = 1'b0;
        alu_we = 1'b1; alu_dir = 5'd5; alu_dato = 32'h11;
        tick();
        checks++; if (RWEN !== 1'b1) begin errors++; $display("FAIL first_alu_rwen: got %0b want 1", RWEN); end
        checks++; if (DirWrite !== 5'd5) begin errors++; $display("FAIL first_alu_dir: got %0d want 5", DirWrite); end
        checks++; if (DatoNuevo !== 32'h11) begin errors++; $display("FAIL first_alu_dato: got %0h want 11", DatoNuevo); end
        alu_we = 1'b0;
        tick();
        checks++; if (RWEN !== 1'b0) begin errors++; $display("FAIL idle_rwen: got %0b want 0", RWEN); end
        checks++; if (DirWrite !== 5'd5) begin errors++; $display("FAIL idle_dir_hold: got %0d want 5", DirWrite); end
    endtask

    task automatic test_fill_drain();
        alu_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            lat_valid = 1'b1; lat_dir = 5'(k + 1); lat_dato = 32'hA1 + 32'(k);
            #1;
            checks++; if (lat_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d: got %0b want 1", k, lat_ready); end
            tick();
            checks++; if (ocupacion !== 3'd1) begin errors++; $display("FAIL fill_ocup%0d: got %0d want 1", k, ocupacion); end
            if (k == 0) begin
                checks++; if (RWEN !== 1'b0) begin errors++; $display("FAIL fill_first_rwen: got %0b want 0", RWEN); end
            end else begin
                checks++; if (RWEN !== 1'b1 || DirWrite !== 5'(k) || DatoNuevo !== 32'hA0 + 32'(k)) begin
                    errors++; $display("FAIL fill_write%0d: got we=%0b r%0d=%0h want we=1 r%0d=%0h",
                                       k, RWEN, DirWrite, DatoNuevo, k, 32'hA0 + 32'(k));
                end
            end
        end
        lat_valid = 1'b0;
        tick();
        checks++; if (RWEN !== 1'b1 || DirWrite !== 5'd4 || DatoNuevo !== 32'hA4) begin
            errors++; $display("FAIL fill_last: got we=%0b r%0d=%0h want we=1 r4=a4", RWEN, DirWrite, DatoNuevo);
        end
        checks++; if (ocupacion !== 3'd0) begin errors++; $display("FAIL drain_ocup: got %0d want 0", ocupacion); end
        tick();
        checks++; if (RWEN !== 1'b0) begin errors++; $display("FAIL drain_idle: got %0b want 0", RWEN); end
    endtask

    task automatic test_full_starve_collision();
        for (int k = 0; k < 4; k++) begin
            alu_we = 1'b1; alu_dir = 5'd7; alu_dato = 32'h70 + 32'(k);
            lat_valid = 1'b1; lat_dir = 5'(k + 1); lat_dato = 32'hB1 + 32'(k);
            #1;
            checks++; if (lat_ready !== 1'b1) begin errors++; $display("FAIL full_ready%0d: got %0b want 1", k, lat_ready); end
            tick();
            checks++; if (RWEN !== 1'b1 || DirWrite !== 5'd7 || DatoNuevo !== 32'h70 + 32'(k)) begin
                errors++; $display("FAIL full_alu%0d: got we=%0b r%0d=%0h want we=1 r7=%0h",
                                   k, RWEN, DirWrite, DatoNuevo, 32'h70 + 32'(k));
            end
            checks++; if (ocupacion !== 3'(k + 1)) begin errors++; $display("FAIL full_ocup%0d: got %0d want %0d", k, ocupacion, k + 1); end
            checks++; if (pide_stall !== (k == 3)) begin errors++; $display("FAIL full_stall%0d: got %0b want %0b", k, pide_stall, k == 3); end
        end
        // Stall cycle: 5th offer is refused, ALU r9 collides.
        alu_dir = 5'd9; alu_dato = 32'h99;
        lat_dir = 5'd5; lat_dato = 32'hB5;
        #1;
        checks++; if (lat_ready !== 1'b0) begin errors++; $display("FAIL full_ready_low: got %0b want 0", lat_ready); end
        tick();
        checks++; if (RWEN !== 1'b1 || DirWrite !== 5'd1 || DatoNuevo !== 32'hB1) begin
            errors++; $display("FAIL stall_head: got we=%0b r%0d=%0h want we=1 r1=b1", RWEN, DirWrite, DatoNuevo);
        end
        checks++; if (ocupacion !== 3'd3) begin errors++; $display("FAIL stall_ocup: got %0d want 3", ocupacion); end
        checks++; if (pide_stall !== 1'b0) begin errors++; $display("FAIL stall_one_cycle: got %0b want 0", pide_stall); end
        checks++; if (err_colision !== 1'b1) begin errors++; $display("FAIL collision_set: got %0b want 1", err_colision); end
        // 5th offer now accepted while r2 pops.
        alu_we = 1'b0;
        tick();
        checks++; if (DirWrite !== 5'd2 || DatoNuevo !== 32'hB2 || ocupacion !== 3'd3) begin
            errors++; $display("FAIL pushpop: got r%0d=%0h ocup=%0d want r2=b2 ocup=3", DirWrite, DatoNuevo, ocupacion);
        end
        lat_valid = 1'b0;
        for (int k = 3; k <= 5; k++) begin
            tick();
            checks++; if (RWEN !== 1'b1 || DirWrite !== 5'(k) || DatoNuevo !== 32'hB0 + 32'(k) || ocupacion !== 3'(5 - k)) begin
                errors++; $display("FAIL drain_r%0d: got we=%0b r%0d=%0h ocup=%0d want we=1 r%0d=%0h ocup=%0d",
                                   k, RWEN, DirWrite, DatoNuevo, ocupacion, k, 32'hB0 + 32'(k), 5 - k);
            end
        end
        tick();
        checks++; if (RWEN !== 1'b0) begin errors++; $display("FAIL full_end_idle: got %0b want 0", RWEN); end
        checks++; if (err_colision !== 1'b1) begin errors++; $display("FAIL collision_sticky: got %0b want 1", err_colision); end
        checks++; if (wrote9 !== 1'b0) begin errors++; $display("FAIL r9_written: got %0b want 0", wrote9); end
    endtask

    task automatic test_zero_reg();
        alu_we = 1'b1; alu_dir = 5'd0; alu_dato = 32'h55;
        lat_valid = 1'b0;
        tick();
        checks++; if (RWEN !== 1'b0) begin errors++; $display("FAIL zero_alu: got %0b want 0", RWEN); end
        alu_we = 1'b0;
        lat_valid = 1'b1; lat_dir = 5'd0; lat_dato = 32'h66;
        #1;
        checks++; if (lat_ready !== 1'b1) begin errors++; $display("FAIL zero_ready: got %0b want 1", lat_ready); end
        tick();
        checks++; if (ocupacion !== 3'd0 || RWEN !== 1'b0) begin
            errors++; $display("FAIL zero_push: got ocup=%0d we=%0b want ocup=0 we=0", ocupacion, RWEN);
        end
        // Hold r6 in the FIFO behind an ALU write, then query r0 and r6.
        alu_we = 1'b1; alu_dir = 5'd8; alu_dato = 32'h88;
        lat_dir = 5'd6; lat_dato = 32'h60;
        tick();
        lat_valid = 1'b0; alu_we = 1'b0;
        rd_dir1 = 5'd0; rd_dir2 = 5'd6;
        #1;
        checks++; if (pend1 !== 1'b0) begin errors++; $display("FAIL zero_pend1: got %0b want 0", pend1); end
        checks++; if (pend2 !== 1'b1) begin errors++; $display("FAIL r6_pend2: got %0b want 1", pend2); end
        tick();
        checks++; if (RWEN !== 1'b1 || DirWrite !== 5'd6 || pend2 !== 1'b0) begin
            errors++; $display("FAIL r6_drain: got we=%0b r%0d pend2=%0b want we=1 r6 pend2=0", RWEN, DirWrite, pend2);
        end
    endtask

    task automatic test_hazard();
        alu_we = 1'b0;
        rd_dir1 = 5'd3; rd_dir2 = 5'd4;
        lat_valid = 1'b1; lat_dir = 5'd3; lat_dato = 32'h1;
        tick();
        checks++; if (pend1 !== 1'b1 || pend2 !== 1'b0) begin
            errors++; $display("FAIL haz_q1: got p1=%0b p2=%0b want p1=1 p2=0", pend1, pend2);
        end
        lat_dato = 32'h2;
        tick();
        checks++; if (RWEN !== 1'b1 || DatoNuevo !== 32'h1 || pend1 !== 1'b1 || pend2 !== 1'b0) begin
            errors++; $display("FAIL haz_first: got we=%0b d=%0h p1=%0b p2=%0b want we=1 d=1 p1=1 p2=0",
                               RWEN, DatoNuevo, pend1, pend2);
        end
        lat_valid = 1'b0;
        tick();
        checks++; if (RWEN !== 1'b1 || DirWrite !== 5'd3 || DatoNuevo !== 32'h2 || pend1 !== 1'b0) begin
            errors++; $display("FAIL haz_second: got we=%0b r%0d=%0h p1=%0b want we=1 r3=2 p1=0",
                               RWEN, DirWrite, DatoNuevo, pend1);
        end
        tick();
        checks++; if (rf[3] !== 32'h2) begin errors++; $display("FAIL haz_r3_final: got %0h want 2", rf[3]); end
    endtask

    task automatic test_reset_clears_err();
        rst_n = 1'b0;
        tick();
        checks++; if (err_colision !== 1'b0) begin errors++; $display("FAIL err_cleared: got %0b want 0", err_colision); end
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_full_starve_collision();
        test_zero_reg();
        test_hazard();
        test_reset_clears_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
